// File: rtl/inst_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue_pkg
// Description : Shared widths and queue entry type for the instruction queue.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_queue_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int INSTRUCTION_WIDTH = 32;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]        pc;
    logic [INSTRUCTION_WIDTH-1:0] inst;
  } iq_entry_t;

  localparam int ENTRY_WIDTH = $bits(iq_entry_t);

endpackage : inst_queue_pkg
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue
// Description : Fetch-to-decode instruction FIFO with first-word fall-through.
//               Define INST_QUEUE_BYPASS_EN for same-cycle bypass when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_pc,
  input  logic [INSTRUCTION_WIDTH-1:0] in_inst,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_pc,
  output logic [INSTRUCTION_WIDTH-1:0] out_inst,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int                 c_PTR_W     = $clog2(DEPTH);
  localparam int                 c_CNT_W     = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [31:0]        c_AFULL_TH  = 32'(AFULL_TH);

  iq_entry_t            r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [c_CNT_W-1:0]   r_count;

  logic                 w_active;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [c_CNT_W-1:0]   w_free;
  iq_entry_t            w_head_entry;

  assign w_active     = ena && !flush;
  assign w_empty      = (r_count == '0);
  assign w_head_entry = r_mem[r_head];
  assign w_free       = c_DEPTH_CNT - r_count;

  // Status flags depend only on the registered count, never on this cycle's traffic.
  assign full        = (r_count == c_DEPTH_CNT);
  assign almost_full = (32'(w_free) <= c_AFULL_TH);
  assign count       = r_count;

`ifdef INST_QUEUE_BYPASS_EN
  logic w_bypass;

  assign w_bypass  = w_active && in_valid && w_empty;
  assign out_valid = !w_empty || w_bypass;
  assign out_pc    = w_empty ? in_pc   : w_head_entry.pc;
  assign out_inst  = w_empty ? in_inst : w_head_entry.inst;
  assign w_pop     = w_active && !w_empty && out_ready;
  // A bypassed word taken by the decoder this cycle never occupies an entry.
  assign w_push    = w_active && in_valid && !full && !(w_bypass && out_ready);
`else
  assign out_valid = !w_empty;
  assign out_pc    = w_head_entry.pc;
  assign out_inst  = w_head_entry.inst;
  assign w_pop     = w_active && out_valid && out_ready;
  assign w_push    = w_active && in_valid && !full;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (ena) begin
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_head <= r_head + c_PTR_W'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + c_CNT_W'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - c_CNT_W'(1);
        end
      end
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= '{pc: in_pc, inst: in_inst};
    end
  end

endmodule : inst_queue
`default_nettype wire

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue entries (power of two, >= 4).
REQ-002 SHALL have parameter AFULL_TH, default 2, free-entry count at or below which almost_full asserts.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port ena  in  1  global enable; low freezes all state.
REQ-006 SHALL have port flush  in  1  discard all entries (redirect/mispredict).
REQ-007 SHALL have port in_valid  in  1  fetch stage presents an instruction.
REQ-008 SHALL have port in_pc  in  32  PC of the presented instruction.
REQ-009 SHALL have port in_inst  in  32  instruction word from i-cache.
REQ-010 SHALL have port full  out  1  count == DEPTH.
REQ-011 SHALL have port almost_full  out  1  (DEPTH - count) <= AFULL_TH; fetch stall request.
REQ-012 SHALL have port out_ready  in  1  decoder accepts head entry.
REQ-013 SHALL have port out_valid  out  1  head entry valid.
REQ-014 SHALL have port out_pc  out  32  head PC.
REQ-015 SHALL have port out_inst  out  32  head instruction.
REQ-016 SHALL have port count  out  log2(DEPTH)+1  occupied entries.

Function
REQ-017 SHALL store (pc, inst) pairs in a circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-018 SHALL push on a rising edge iff ena && !flush && in_valid && !full; entry written at tail, tail+1.
REQ-019 SHALL pop on a rising edge iff ena && !flush && out_valid && out_ready; head+1.
REQ-020 SHALL update count +1 (push only), -1 (pop only), unchanged (both or neither).
REQ-021 SHALL, when full, reject the push even if a pop occurs the same cycle; in_valid data is dropped, upstream must hold it.
REQ-022 SHALL drive out_valid = (count != 0), out_pc/out_inst = head entry, first-word fall-through; push-to-out_valid latency 1 cycle.
REQ-023 SHALL, on flush && ena, set head = tail = count = 0 next edge; simultaneous push and pop are ignored.
REQ-024 SHALL, with ena low, hold pointers, count and storage; outputs keep reflecting current head.
REQ-025 SHALL derive full and almost_full combinationally from registered count only.
REQ-026 SHALL leave out_pc/out_inst don't-care when out_valid is low.

Reset
REQ-027 SHALL, on rst asserted, asynchronously clear head, tail, count; out_valid, full, almost_full = 0 (almost_full = 1 only if DEPTH <= AFULL_TH).
REQ-028 SHALL not require storage array reset; rst mid-operation discards all entries identically to flush.

Configuration
REQ-029 SHALL honour macro INST_QUEUE_BYPASS_EN: when defined and count == 0, in_valid && ena && !flush, out_valid = 1 same cycle with out_pc/out_inst = in_pc/in_inst; if out_ready the entry is consumed without being written (count stays 0), else it is pushed normally.
REQ-030 SHALL, without INST_QUEUE_BYPASS_EN, behave per REQ-022 (minimum 1-cycle latency, no input-to-output combinational path).

Structure
REQ-031 SHALL take DATA_WIDTH and INSTRUCTION_WIDTH (32) and the queue entry struct/width from the shared constants package.
REQ-032 SHALL be a single module; no sub-module required (storage is an inferred register array).

Verification
REQ-033 SHALL cover: reset, push pc=0x0/0x4/0x8 -> out_valid next cycle, pops return 0x0,0x4,0x8 in order, count 3->0.
REQ-034 SHALL cover: 16 pushes with out_ready=0 -> full=1 at count 16, almost_full from count 14; 17th push dropped, head still 0x0.
REQ-035 SHALL cover: full queue, in_valid and out_ready same cycle -> pop only, count 15, pushed word absent.
REQ-036 SHALL cover: 5 entries, flush with in_valid and out_ready high -> next cycle count 0, out_valid 0, no entry retained.
REQ-037 SHALL cover: push/pop 40 entries with random out_ready -> PCs 0x0..0x9C emerged in order across pointer wrap.
REQ-038 SHALL cover: with INST_QUEUE_BYPASS_EN, empty queue, in_pc=0x100, out_ready=1 -> out_valid and out_pc=0x100 same cycle, count remains 0.
